// File: rtl/uart_pkg.sv
// Shared definitions for the controller-link UART.
// Holds the transmitter state encoding and the frame/baud constants
// used by uart_tx and its byte FIFO.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int UART_DATA_BITS         = 8;
  // 3.226 MHz / 28 = 115200 baud
  localparam int UART_CLKS_PER_BIT_115K = 28;

endpackage

// File: rtl/uart_tx_fifo.sv
// Purpose: synchronous byte FIFO feeding the UART transmitter.
// Latency: written on the push edge, visible to a pop from the next cycle (no bypass).
// Backpressure: push ignored while full, even if a pop happens in the same cycle.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset (flushes pointers)
//   i_push, i_din    write request and data
//   i_pop, o_dout    read request; o_dout shows the head entry combinationally
//   o_full, o_empty  status derived from the registered pointers
//   o_level          occupancy, 0..DEPTH
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = UART_DATA_BITS
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the low bits match.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/uart_tx.sv
// Purpose: 8-bit UART transmitter (LSB first, 1 start, 1 stop) sending status bytes to the controller.
// Latency: push at edge N into an empty FIFO while idle drives the start bit from edge N+2.
// Backpressure: o_ready low while the internal FIFO is full; frames leave back to back.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
// Ports:
//   i_clk, i_rst_n   CLK_3226K domain clock, asynchronous active-low reset
//   i_data, i_valid  byte producer port; byte accepted when i_valid && o_ready
//   o_ready          FIFO not full
//   o_tx             registered serial line, idles high
//   o_busy           frame in progress or bytes still queued
//   o_level          FIFO occupancy
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115K,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [7:0]                    i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int              BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      BIT_LAST  = 3'(UART_DATA_BITS - 1);

  tx_state_t   r_state, w_state_nxt;
  logic [BW-1:0] r_baud, w_baud_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_tx, w_tx_nxt;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic        w_baud_end;
  logic [7:0]  w_dout;
`ifdef UART_TX_PARITY_EN
  logic        r_par;
`endif

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_valid),
    .i_pop   (w_pop),
    .i_din   (i_data),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_level)
  );

  // Full is a function of registered pointers only, so o_ready is glitch-free.
  assign o_ready    = !w_full;
  assign o_busy     = (r_state != IDLE) || !w_empty;
  assign o_tx       = r_tx;
  assign w_baud_end = (r_baud == BAUD_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity is captured from the FIFO head when the byte is loaded.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_par <= 1'b0;
    else if (w_pop) r_par <= ^w_dout;
  end
`endif

  // The line level is derived from the current state and registered,
  // which puts the start bit one edge after the pop (N+2 from the push).
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = 1'b1;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_dout;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = START;
        end
      end
      START: begin
        w_tx_nxt = 1'b0;
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_state_nxt = DATA;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == BIT_LAST) begin
            w_bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        w_tx_nxt = r_par;
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_state_nxt = STOP;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
`endif
      STOP: begin
        w_tx_nxt = 1'b1;
        if (w_baud_end) begin
          w_baud_nxt = '0;
          // Chain straight into the next frame when bytes are waiting.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_dout;
            w_bit_nxt   = '0;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset, single frame, back-to-back frames,
// full FIFO, mid-frame reset and the optional parity bit.
module tb_uart_tx;

  localparam int CPB = 28;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready;
  logic       tx;
  logic       busy;
  logic [3:0] level;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  (data),
    .i_valid (valid),
    .o_ready (ready),
    .o_tx    (tx),
    .o_busy  (busy),
    .o_level (level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Receiver model: finds the start bit, samples mid-bit, checks start and stop levels.
  task automatic rx_byte(output logic [7:0] b, output logic p, output int s, output bit ok);
    int   w;
    logic st;
    logic sp;
    b = 8'h00; p = 1'b0; s = 0; ok = 1'b0; w = 0;
    while (tx !== 1'b0 && w < 3000) begin
      tick(1);
      w++;
    end
    if (tx !== 1'b0) return;
    s = cyc;
    tick(CPB / 2);
    st = tx;
    for (int i = 0; i < 8; i++) begin
      tick(CPB);
      b[i] = tx;
    end
`ifdef UART_TX_PARITY_EN
    tick(CPB);
    p = tx;
`endif
    tick(CPB);
    sp = tx;
    ok = (st === 1'b0) && (sp === 1'b1);
  endtask

  task automatic wait_idle(output int d, output bit ok);
    int w;
    w = 0;
    while (busy !== 1'b0 && w < 5000) begin
      tick(1);
      w++;
    end
    d = cyc;
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    #2;
    n_tests++;
    if ({tx, ready, busy, level} !== {1'b1, 1'b1, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_async: tx/ready/busy/level=%b/%b/%b/%0d expected 1/1/0/0", tx, ready, busy, level);
    end
    tick(5);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if ({tx, ready, busy, level} !== {1'b1, 1'b1, 1'b0, 4'd0}) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_idle: %0d bad cycles, expected 0", bad);
    end
  endtask

  task automatic test_single();
    logic [7:0] b;
    logic p;
    int s, cn, d;
    bit ok, iok;
    data = 8'hA5; valid = 1'b1;
    tick(1);
    valid = 1'b0;
    cn = cyc;
    n_tests++;
    if (level !== 4'd1 || busy !== 1'b1 || tx !== 1'b1) begin
      n_fail++;
      $display("FAIL single_push: level=%0d busy=%b tx=%b expected 1/1/1", level, busy, tx);
    end
    tick(1);
    n_tests++;
    if (tx !== 1'b1 || level !== 4'd0) begin
      n_fail++;
      $display("FAIL single_pop: tx=%b level=%0d expected 1/0", tx, level);
    end
    rx_byte(b, p, s, ok);
    n_tests++;
    if (!ok || b !== 8'hA5 || s !== cn + 2) begin
      n_fail++;
      $display("FAIL single_frame: ok=%0d byte=%h start=%0d expected 1/a5/%0d", ok, b, s, cn + 2);
    end
    tick(s + FRAME - 2 - cyc);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy_hold: busy=%b expected 1", busy);
    end
    wait_idle(d, iok);
    n_tests++;
    if (!iok || d !== s + FRAME - 1) begin
      n_fail++;
      $display("FAIL single_busy_drop: drop cycle=%0d expected %0d", d, s + FRAME - 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    logic p;
    int s[3];
    int d;
    bit ok, iok;
    for (int i = 0; i < 3; i++) begin
      data = 8'(i + 1); valid = 1'b1;
      tick(1);
    end
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_byte(b, p, s[i], ok);
      n_tests++;
      if (!ok || b !== 8'(i + 1)) begin
        n_fail++;
        $display("FAIL b2b_byte%0d: ok=%0d byte=%h expected %h", i, ok, b, 8'(i + 1));
      end
    end
    n_tests++;
    if (s[1] - s[0] !== FRAME || s[2] - s[1] !== FRAME) begin
      n_fail++;
      $display("FAIL b2b_gap: spacing %0d,%0d expected %0d", s[1] - s[0], s[2] - s[1], FRAME);
    end
    wait_idle(d, iok);
    n_tests++;
    if (!iok || d - s[0] + 1 !== 3 * FRAME) begin
      n_fail++;
      $display("FAIL b2b_total: %0d cycles expected %0d", d - s[0] + 1, 3 * FRAME);
    end
  endtask

  task automatic test_full();
    logic [7:0] b;
    logic p;
    logic [4:0] st[10];
    int s, d;
    bit ok, iok;
    // Ten pushes on consecutive edges; one byte is popped after the first,
    // so the ninth fills the FIFO and the tenth is rejected.
    valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data = 8'h10 + 8'(i);
      tick(1);
      st[i] = {ready, level};
    end
    valid = 1'b0;
    n_tests++;
    if (st[7] !== {1'b1, 4'd7}) begin
      n_fail++;
      $display("FAIL full_pre: ready/level=%b expected 1/7", st[7]);
    end
    n_tests++;
    if (st[8] !== {1'b0, 4'd8} || st[9] !== {1'b0, 4'd8}) begin
      n_fail++;
      $display("FAIL full_hold: %b %b expected ready 0 level 8", st[8], st[9]);
    end
    for (int i = 0; i < 9; i++) begin
      rx_byte(b, p, s, ok);
      n_tests++;
      if (!ok || b !== 8'h10 + 8'(i)) begin
        n_fail++;
        $display("FAIL full_byte%0d: ok=%0d byte=%h expected %h", i, ok, b, 8'h10 + 8'(i));
      end
    end
    wait_idle(d, iok);
    n_tests++;
    if (!iok || d - s + 1 !== FRAME || level !== 4'd0) begin
      n_fail++;
      $display("FAIL full_drop10: tail=%0d level=%0d expected %0d/0", d - s + 1, level, FRAME);
    end
  endtask

  task automatic test_mid_reset();
    int lows;
    for (int i = 0; i < 5; i++) begin
      data = (i == 0) ? 8'hFF : 8'h00;
      valid = 1'b1;
      tick(1);
    end
    valid = 1'b0;
    // Push edges N..N+4; bit 3 is on the line from N+114 to N+142.
    tick(116);
    n_tests++;
    if (busy !== 1'b1 || level !== 4'd4) begin
      n_fail++;
      $display("FAIL midrst_pre: busy=%b level=%0d expected 1/4", busy, level);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({tx, ready, busy, level} !== {1'b1, 1'b1, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL midrst_now: tx/ready/busy/level=%b/%b/%b/%0d expected 1/1/0/0", tx, ready, busy, level);
    end
    #2;
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 600; i++) begin
      tick(1);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    n_tests++;
    if (lows !== 0) begin
      n_fail++;
      $display("FAIL midrst_quiet: %0d active cycles after release, expected 0", lows);
    end
  endtask

  task automatic test_parity();
    logic [7:0] b;
    logic p;
    int s, d;
    bit ok, iok;
    data = 8'h07; valid = 1'b1;
    tick(1);
    valid = 1'b0;
    rx_byte(b, p, s, ok);
    n_tests++;
    if (!ok || b !== 8'h07) begin
      n_fail++;
      $display("FAIL par_byte: ok=%0d byte=%h expected 07", ok, b);
    end
`ifdef UART_TX_PARITY_EN
    n_tests++;
    if (p !== 1'b1) begin
      n_fail++;
      $display("FAIL par_bit: parity=%b expected 1", p);
    end
`endif
    wait_idle(d, iok);
    n_tests++;
    if (!iok || d - s + 1 !== FRAME) begin
      n_fail++;
      $display("FAIL par_len: frame=%0d expected %0d", d - s + 1, FRAME);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_mid_reset();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
